// File: rtl/autofire_multi_if.sv
// Button bus between the input mapper (master) and the autofire controller (slave).
interface autofire_multi_if #(
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned RATE_W   = 6
) ();
   logic [CHANNELS-1:0] enable;
   logic [RATE_W-1:0]   rate;
   logic [CHANNELS-1:0] btn_in;
   logic [CHANNELS-1:0] btn_out;
   logic [CHANNELS-1:0] firing;

   modport master (
      output enable, rate, btn_in,
      input  btn_out, firing
   );

   modport slave (
      input  enable, rate, btn_in,
      output btn_out, firing
   );
endinterface

// File: rtl/autofire_multi.sv
// Multi-channel autofire: each held, enabled button toggles at a shared rate,
// timed by a per-channel phase accumulator so fractional half-periods average out.
module autofire_multi #(
   parameter int unsigned CLK      = 12_000_000,
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned RATE_W   = 6
) (
   input  logic              clk,
   input  logic              reset,
   autofire_multi_if.slave   bus
);
   localparam int unsigned RATE_MAX = (2 ** RATE_W) - 1;
   localparam int unsigned ACC_W    = $clog2(CLK + 2 * RATE_MAX);

   if (CLK <= 2 * RATE_MAX) begin : g_bad_clk
      $error("autofire_multi: CLK must exceed 2*(2**RATE_W-1)");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FIRE_ON  = 2'd1,
      FIRE_OFF = 2'd2
   } state_e;

   state_e              state_q [CHANNELS];
   logic [ACC_W-1:0]    acc_q   [CHANNELS];
   logic [CHANNELS-1:0] btn_out_q;
   logic [CHANNELS-1:0] firing_q;
   logic [CHANNELS-1:0] btn_prev_q;
   logic [CHANNELS-1:0] en_prev_q;

   logic [ACC_W-1:0]    step_c;
   logic [ACC_W-1:0]    sum_c   [CHANNELS];
   logic [CHANNELS-1:0] wrap_c;
   logic [CHANNELS-1:0] start_c;
   logic                rate_zero_c;

   // Phase step is 2*rate per cycle; a wrap past CLK marks a half-period boundary.
   always_comb begin
      step_c      = ACC_W'({bus.rate, 1'b0});
      rate_zero_c = (bus.rate == '0);
      start_c     = (bus.btn_in & bus.enable) & ~(btn_prev_q & en_prev_q);
      wrap_c      = '0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
         sum_c[ch]  = acc_q[ch] + step_c;
         wrap_c[ch] = (sum_c[ch] >= ACC_W'(CLK));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_out_q  <= '0;
         firing_q   <= '0;
         btn_prev_q <= '0;
         en_prev_q  <= '0;
         for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            state_q[ch] <= IDLE;
            acc_q[ch]   <= '0;
         end
      end else begin
         btn_prev_q <= bus.btn_in;
         en_prev_q  <= bus.enable;
         for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            unique case (state_q[ch])
               FIRE_ON, FIRE_OFF: begin
                  // Exit takes priority over the toggle in the same cycle.
                  if (!bus.btn_in[ch] || !bus.enable[ch] || rate_zero_c) begin
                     state_q[ch]   <= IDLE;
                     btn_out_q[ch] <= bus.btn_in[ch];
                     firing_q[ch]  <= 1'b0;
                     acc_q[ch]     <= '0;
                  end else if (wrap_c[ch]) begin
                     acc_q[ch]    <= sum_c[ch] - ACC_W'(CLK);
                     firing_q[ch] <= 1'b1;
                     if (state_q[ch] == FIRE_ON) begin
                        state_q[ch]   <= FIRE_OFF;
                        btn_out_q[ch] <= 1'b0;
                     end else begin
                        state_q[ch]   <= FIRE_ON;
                        btn_out_q[ch] <= 1'b1;
                     end
                  end else begin
                     acc_q[ch]    <= sum_c[ch];
                     firing_q[ch] <= 1'b1;
                  end
               end
               default: begin
                  if (start_c[ch] && !rate_zero_c) begin
                     state_q[ch]   <= FIRE_ON;
                     btn_out_q[ch] <= 1'b1;
                     firing_q[ch]  <= 1'b1;
                     acc_q[ch]     <= '0;
                  end else begin
                     state_q[ch]   <= IDLE;
                     btn_out_q[ch] <= bus.btn_in[ch];
                     firing_q[ch]  <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   assign bus.btn_out = btn_out_q;
   assign bus.firing  = firing_q;

endmodule

// File: tb/tb_autofire_multi.sv
// Directed bench for autofire_multi with CLK=1000, two channels.
module tb_autofire_multi;
   localparam int unsigned CLK_HZ = 1000;
   localparam int unsigned CH     = 2;
   localparam int unsigned RW     = 6;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   autofire_multi_if #(.CHANNELS(CH), .RATE_W(RW)) bus ();

   autofire_multi #(.CLK(CLK_HZ), .CHANNELS(CH), .RATE_W(RW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int tog_cnt;
      int first_tog;
      int sixth_tog;
      logic prev_b;

      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.enable = '0;
      bus.rate   = '0;
      bus.btn_in = '0;
      step(); step();
      chk("reset_btn_out", 32'(bus.btn_out), 32'h0);
      chk("reset_firing", 32'(bus.firing), 32'h0);
      reset = 1'b0;
      step();
      chk("idle_btn_out", 32'(bus.btn_out), 32'h0);

      // Basic burst on channel 0, rate 5 -> 100-cycle half periods.
      bus.rate   = 6'd5;
      bus.enable = 2'b01;
      bus.btn_in = 2'b01;
      for (int n = 1; n <= 250; n++) begin
         step();
         chk("burst_btn_out", 32'(bus.btn_out), (n <= 100 || n > 200) ? 32'h1 : 32'h0);
         chk("burst_firing", 32'(bus.firing), 32'h1);
      end
      // Release during FIRE_ON.
      bus.btn_in = 2'b00;
      step();
      chk("release_btn_out", 32'(bus.btn_out), 32'h0);
      chk("release_firing", 32'(bus.firing), 32'h0);
      for (int n = 0; n < 9; n++) step();
      // Re-press: full fresh ON phase.
      bus.btn_in = 2'b01;
      for (int n = 1; n <= 102; n++) begin
         step();
         chk("repress_btn_out", 32'(bus.btn_out), (n <= 100) ? 32'h1 : 32'h0);
      end
      bus.btn_in = 2'b00;
      step();
      chk("repress_release", 32'(bus.btn_out), 32'h0);

      // Disabled channels are plain passthrough.
      bus.enable = 2'b00;
      bus.btn_in = 2'b11;
      for (int n = 1; n <= 300; n++) begin
         step();
         chk("disabled_btn_out", 32'(bus.btn_out), 32'h3);
         chk("disabled_firing", 32'(bus.firing), 32'h0);
      end
      bus.btn_in = 2'b00;
      step();
      chk("disabled_release", 32'(bus.btn_out), 32'h0);

      // Rate 3: toggles after 167,167,166,... cycles; 6 toggles span 1000 cycles.
      bus.rate   = 6'd3;
      bus.enable = 2'b01;
      bus.btn_in = 2'b01;
      step();
      chk("rate3_start", 32'(bus.btn_out), 32'h1);
      prev_b = bus.btn_out[0];
      tog_cnt = 0;
      first_tog = 0;
      sixth_tog = 0;
      for (int n = 2; n <= 1100; n++) begin
         step();
         if (bus.btn_out[0] !== prev_b) begin
            tog_cnt++;
            if (tog_cnt == 1) first_tog = n;
            if (tog_cnt == 6) sixth_tog = n;
         end
         prev_b = bus.btn_out[0];
      end
      chk("rate3_first_toggle", 32'(first_tog), 32'd168);
      chk("rate3_sixth_toggle", 32'(sixth_tog), 32'd1001);
      chk("rate3_toggle_count", 32'(tog_cnt), 32'd6);
      bus.btn_in = 2'b00;
      step();
      chk("rate3_release", 32'(bus.btn_out), 32'h0);

      // Enable rising while channel 1 is held starts a burst.
      bus.rate   = 6'd5;
      bus.enable = 2'b00;
      bus.btn_in = 2'b10;
      step(); step();
      chk("held_pass_btn_out", 32'(bus.btn_out), 32'h2);
      chk("held_pass_firing", 32'(bus.firing), 32'h0);
      bus.enable = 2'b10;
      for (int n = 1; n <= 101; n++) begin
         step();
         chk("en_rise_btn_out", 32'(bus.btn_out), (n <= 100) ? 32'h2 : 32'h0);
         chk("en_rise_firing", 32'(bus.firing), 32'h2);
      end
      // Drop enable in FIRE_OFF: passthrough shows the held button.
      bus.enable = 2'b00;
      step();
      chk("en_drop_btn_out", 32'(bus.btn_out), 32'h2);
      chk("en_drop_firing", 32'(bus.firing), 32'h0);
      bus.btn_in = 2'b00;
      step();

      // Reset during FIRE_OFF with rate 0 and button held.
      bus.enable = 2'b01;
      bus.btn_in = 2'b01;
      for (int n = 1; n <= 101; n++) step();
      chk("pre_reset_off", 32'(bus.btn_out), 32'h0);
      chk("pre_reset_firing", 32'(bus.firing), 32'h1);
      bus.rate = 6'd0;
      reset = 1'b1;
      step();
      chk("mid_reset_btn_out", 32'(bus.btn_out), 32'h0);
      chk("mid_reset_firing", 32'(bus.firing), 32'h0);
      step();
      reset = 1'b0;
      for (int n = 1; n <= 50; n++) begin
         step();
         chk("rate0_btn_out", 32'(bus.btn_out), 32'h1);
         chk("rate0_firing", 32'(bus.firing), 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/autofire_multi.md
Name: autofire_multi

Overview:
- Multi-channel autofire/turbo controller; successor to the single-button autofire block.
- Each channel toggles its output at a shared rate only while its button is held and autofire is enabled for that channel.
- Uses a per-channel phase accumulator instead of a divide, so half-periods are exact on average for any rate, including non-integer ones.
- Sits between the input mapper and the core's joystick/button inputs.

Parameters:
- CLK, 12_000_000, system clock frequency in Hz.
- CHANNELS, 8, number of independent button channels (1..32).
- RATE_W, 6, width of the rate input.
- Elaboration check: CLK > 2*(2**RATE_W-1); otherwise error.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  CHANNELS  per-channel autofire enable.
- rate  input  RATE_W  full press/release cycles per second, shared by all channels; 0 means no toggling.
- btn_in  input  CHANNELS  raw button state, already synchronous to clk, 1 = pressed.
- btn_out  output  CHANNELS  registered button output.
- firing  output  CHANNELS  1 while the channel is in FIRE_ON or FIRE_OFF.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - btn_out = 0, firing = 0.
  - All channel states = IDLE.
  - All accumulators = 0.
  - Registered previous btn_in and enable = 0.
- All outputs are registered; latency from btn_in to btn_out is 1 cycle.
- Per-channel states: IDLE, FIRE_ON, FIRE_OFF.
- Start condition: (btn_in & enable) is 1 this cycle and was 0 the previous cycle. This covers a press while enabled and enable rising while the button is held.
- IDLE:
  - btn_out <= btn_in (passthrough).
  - On start condition with rate != 0: go to FIRE_ON, acc <= 0, btn_out <= 1.
- FIRE_ON / FIRE_OFF:
  - Each cycle sum = acc + 2*rate.
  - If sum >= CLK: acc <= sum - CLK, toggle state and btn_out (FIRE_ON -> FIRE_OFF with btn_out 0; FIRE_OFF -> FIRE_ON with btn_out 1).
  - Else: acc <= sum, state and btn_out unchanged.
- Exit from FIRE states (checked before the toggle, same cycle):
  - btn_in = 0: IDLE, btn_out <= 0, acc <= 0.
  - enable = 0: IDLE, btn_out <= btn_in, acc <= 0.
  - rate = 0: IDLE, btn_out <= btn_in; a held button reads steady pressed.
- Half-period is CLK/(2*rate) cycles on average. The first ON phase after a start is a full half-period because acc is cleared at the start.
- A rate change mid-burst takes effect on the next accumulate; acc is not cleared.
- Accumulator width: clog2(CLK + 2*(2**RATE_W-1)) bits, unsigned. The subtraction never underflows.
- Channels are independent; simultaneous starts on several channels proceed in lockstep.
- Reset mid-burst returns btn_out to 0 on the next edge regardless of btn_in.
- firing = (state != IDLE), registered with the state.

Test Plan:
- CLK=1000, CHANNELS=2, rate=5, enable=01. Press btn_in[0] at cycle P and hold:
  - btn_out[0]=1 for cycles P+1..P+100, 0 for P+101..P+200, 1 from P+201.
  - firing[0]=1 from P+1.
- Same setup, enable=00. btn_in=11 -> btn_out=11 one cycle later; btn_out never toggles, firing stays 00.
- Same setup, release btn_in[0] during a FIRE_ON phase -> btn_out[0]=0 and firing[0]=0 on the next cycle.
- Press again 10 cycles later -> a fresh full 100-cycle ON phase (acc was cleared).
- CLK=1000, rate=3 (half-period 166.67 cycles): over 6 toggles, total cycles = 1000 +/- 1.
- Hold btn_in[1] with enable[1]=0, then raise enable[1] at cycle E -> FIRE_ON from E+1 with a full ON phase.
- Drop enable[1] mid-burst -> btn_out[1]=1 (passthrough) the next cycle.
- Assert reset during FIRE_OFF with rate=0 and btn_in held:
  - After reset: btn_out=0, firing=0.
  - After reset release: btn_out=1 steady (rate 0 gives passthrough, no toggling).
